// File: rtl/io_map_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | io_map_pkg                                                           |
// | Register map, control-bit layout and shared constants for the IO    |
// | page responder on the pipeline's data bus.                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package io_map_pkg;

   // Value of wb_addr[29:14] that selects the IO page
   localparam logic [15:0] IO_PAGE_DEFAULT = 16'hFFFF;

   // Word offsets within the IO page (wb_addr[13:0])
   localparam logic [13:0] OFF_KDATA = 14'h000;
   localparam logic [13:0] OFF_SDATA = 14'h001;
   localparam logic [13:0] OFF_LEDR  = 14'h002;
   localparam logic [13:0] OFF_HEX   = 14'h003;
   localparam logic [13:0] OFF_TCNT  = 14'h008;
   localparam logic [13:0] OFF_TLIM  = 14'h009;
   localparam logic [13:0] OFF_KCTRL = 14'h040;
   localparam logic [13:0] OFF_SCTRL = 14'h041;
   localparam logic [13:0] OFF_TCTL  = 14'h048;

   // Bit positions inside every status/control register
   localparam int CTRL_READY = 0;
   localparam int CTRL_OVR   = 1;
   localparam int CTRL_IE    = 4;

   // Index of each status/control block
   localparam int NUM_CTRL = 3;
   localparam int IDX_KEY  = 0;
   localparam int IDX_SW   = 1;
   localparam int IDX_TMR  = 2;

   // Read value the memory stage substitutes when a load errors
   localparam logic [31:0] BUS_ERR_DATA = 32'h13371337;

   // Control fields as carried by a bus write
   typedef struct packed {
      logic ie;
      logic overrun;
      logic ready;
   } ctrl_t;

   // Place the three control bits at their register positions
   function automatic logic [31:0] ctrl_word(input logic ready,
                                             input logic overrun,
                                             input logic ie);
      logic [31:0] w;
      w             = '0;
      w[CTRL_READY] = ready;
      w[CTRL_OVR]   = overrun;
      w[CTRL_IE]    = ie;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/io_status_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | io_status_ctrl                                                       |
// | Sticky ready/overrun status with interrupt enable for one event     |
// | source. ready/overrun are write-0-to-clear, ie is plain read/write. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module io_status_ctrl
   import io_map_pkg::*;
(
   input  logic  clk,
   input  logic  reset_n,
   input  logic  evt,
   input  logic  clr_by_read,
   input  logic  wr_en,
   input  ctrl_t wr_data,
   output logic  ready,
   output logic  overrun,
   output logic  ie
);

   logic clearing;
   logic ready_nxt;
   logic overrun_nxt;

   // Next status: clears apply first, a same-cycle event then wins for ready
   always_comb begin
      clearing    = clr_by_read | (wr_en & ~wr_data.ready);
      ready_nxt   = ready;
      overrun_nxt = overrun;
      if (clearing) begin
         ready_nxt = 1'b0;
      end
      if (wr_en && !wr_data.overrun) begin
         overrun_nxt = 1'b0;
      end
      if (evt) begin
         ready_nxt = 1'b1;
         // An event that lands on an unconsumed ready is an overrun,
         // unless software is consuming it in this very cycle.
         if (ready && !clearing) begin
            overrun_nxt = 1'b1;
         end
      end
   end

   // Status/enable register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ready   <= 1'b0;
         overrun <= 1'b0;
         ie      <= 1'b0;
      end else begin
         ready   <= ready_nxt;
         overrun <= overrun_nxt;
         if (wr_en) begin
            ie <= wr_data.ie;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/wb_io_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_io_responder                                                      |
// | Pipelined Wishbone slave for the IO page: keys, switches, LEDs, HEX |
// | and an interval timer, with sticky status and an interrupt output.  |
// | Addresses outside the page are ignored so another slave answers.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_io_responder
   import io_map_pkg::*;
#(
   parameter logic [15:0] IO_PAGE  = IO_PAGE_DEFAULT,
   parameter int unsigned PRESCALE = 100000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   input  logic        wb_we,
   input  logic [29:0] wb_addr,
   input  logic [31:0] wb_mosi,
   input  logic [3:0]  wb_sel,
   output logic        wb_ack,
   output logic        wb_stall,
   output logic        wb_err,
   output logic [31:0] wb_miso,
   input  logic [3:0]  i_key,
   input  logic [9:0]  i_sw,
   output logic [9:0]  o_ledr,
   output logic [23:0] o_hex,
   output logic        o_irq
);

   localparam int unsigned     PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST    = PS_W'(PRESCALE - 1);
   localparam logic [1:0]      PRIME_DONE = 2'd3;

   // Bus decode
   logic        accept;
   logic [13:0] offset;
   logic        mapped;
   logic        writable;
   logic        req_err;
   logic        wr_ok;
   logic        rd_ok;
   logic [31:0] rd_data;
   ctrl_t       wr_ctrl;

   // Response pipeline
   logic        ack_q;
   logic        err_q;
   logic [31:0] miso_q;

   // Input synchronizers and event detection
   logic [3:0]  key_meta;
   logic [3:0]  key_sync;
   logic [3:0]  key_prev;
   logic [9:0]  sw_meta;
   logic [9:0]  sw_sync;
   logic [9:0]  sw_prev;
   logic [1:0]  prime_cnt;
   logic        primed;

   // Board and timer registers
   logic [9:0]      ledr;
   logic [23:0]     hex;
   logic [31:0]     tcnt;
   logic [31:0]     tlim;
   logic [PS_W-1:0] presc;
   logic            tick;
   logic            tlim_hit;

   // Status/control blocks
   logic [NUM_CTRL-1:0] evt_v;
   logic [NUM_CTRL-1:0] clr_v;
   logic [NUM_CTRL-1:0] wr_v;
   logic [NUM_CTRL-1:0] rdy_v;
   logic [NUM_CTRL-1:0] ovr_v;
   logic [NUM_CTRL-1:0] ie_v;
   logic                irq_q;

   assign accept = wb_cyc & wb_stb & (wb_addr[29:14] == IO_PAGE);
   assign offset = wb_addr[13:0];

   // Address decode and read mux; values are sampled before this edge's updates
   always_comb begin
      mapped   = 1'b1;
      writable = 1'b1;
      rd_data  = '0;
      case (offset)
         OFF_KDATA: begin
            rd_data[3:0] = key_sync;
            writable     = 1'b0;
         end
         OFF_SDATA: begin
            rd_data[9:0] = sw_sync;
            writable     = 1'b0;
         end
         OFF_KCTRL: rd_data = ctrl_word(rdy_v[IDX_KEY], ovr_v[IDX_KEY], ie_v[IDX_KEY]);
         OFF_SCTRL: rd_data = ctrl_word(rdy_v[IDX_SW], ovr_v[IDX_SW], ie_v[IDX_SW]);
         OFF_TCTL:  rd_data = ctrl_word(rdy_v[IDX_TMR], ovr_v[IDX_TMR], ie_v[IDX_TMR]);
         OFF_LEDR:  rd_data[9:0]  = ledr;
         OFF_HEX:   rd_data[23:0] = hex;
         OFF_TCNT:  rd_data = tcnt;
         OFF_TLIM:  rd_data = tlim;
         default:   mapped = 1'b0;
      endcase
   end

   // Only full-word writes to writable, mapped registers take effect
   assign req_err = ~mapped | (wb_we & (~writable | (wb_sel != 4'b1111)));
   assign wr_ok   = accept & wb_we & ~req_err;
   assign rd_ok   = accept & ~wb_we & ~req_err;

   assign wr_ctrl.ready   = wb_mosi[CTRL_READY];
   assign wr_ctrl.overrun = wb_mosi[CTRL_OVR];
   assign wr_ctrl.ie      = wb_mosi[CTRL_IE];

   assign wr_v[IDX_KEY]  = wr_ok & (offset == OFF_KCTRL);
   assign wr_v[IDX_SW]   = wr_ok & (offset == OFF_SCTRL);
   assign wr_v[IDX_TMR]  = wr_ok & (offset == OFF_TCTL);
   assign clr_v[IDX_KEY] = rd_ok & (offset == OFF_KDATA);
   assign clr_v[IDX_SW]  = rd_ok & (offset == OFF_SDATA);
   assign clr_v[IDX_TMR] = 1'b0;

   // Response register: one ack or err the cycle after each accept
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         miso_q <= '0;
      end else begin
         ack_q  <= accept & ~req_err;
         err_q  <= accept & req_err;
         miso_q <= rd_ok ? rd_data : 32'd0;
      end
   end

   // A master that has dropped cyc no longer wants the response
   assign wb_ack   = ack_q & wb_cyc;
   assign wb_err   = err_q & wb_cyc;
   assign wb_miso  = wb_ack ? miso_q : 32'd0;
   assign wb_stall = 1'b0;

   // Two-flop synchronizers, previous-value history and start-up prime counter
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         key_meta  <= '0;
         key_sync  <= '0;
         key_prev  <= '0;
         sw_meta   <= '0;
         sw_sync   <= '0;
         sw_prev   <= '0;
         prime_cnt <= '0;
      end else begin
         key_meta <= i_key;
         key_sync <= key_meta;
         key_prev <= key_sync;
         sw_meta  <= i_sw;
         sw_sync  <= sw_meta;
         sw_prev  <= sw_sync;
         if (prime_cnt != PRIME_DONE) begin
            prime_cnt <= prime_cnt + 2'd1;
         end
      end
   end

   // The synced value jumps from 0 to the pin state right after reset;
   // hold off detection until the history register has caught up.
   assign primed              = (prime_cnt == PRIME_DONE);
   assign evt_v[IDX_KEY]      = primed & (key_sync != key_prev);
   assign evt_v[IDX_SW]       = primed & (sw_sync != sw_prev);

   assign tick                = (presc == PS_LAST);
   assign tlim_hit            = (tlim != 32'd0) && (tcnt == (tlim - 32'd1));
   assign evt_v[IDX_TMR]      = tick & tlim_hit;

   // Prescaler, timer count and limit
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         presc <= '0;
         tcnt  <= '0;
         tlim  <= '0;
      end else begin
         // A new limit restarts the tick period from zero
         if (tick || (wr_ok && (offset == OFF_TLIM))) begin
            presc <= '0;
         end else begin
            presc <= presc + 1'b1;
         end
         if (wr_ok && (offset == OFF_TCNT)) begin
            tcnt <= wb_mosi;
         end else if (tick) begin
            tcnt <= tlim_hit ? 32'd0 : tcnt + 32'd1;
         end
         if (wr_ok && (offset == OFF_TLIM)) begin
            tlim <= wb_mosi;
         end
      end
   end

   // LED and HEX output registers
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         ledr <= '0;
         hex  <= '0;
      end else begin
         if (wr_ok && (offset == OFF_LEDR)) begin
            ledr <= wb_mosi[9:0];
         end
         if (wr_ok && (offset == OFF_HEX)) begin
            hex <= wb_mosi[23:0];
         end
      end
   end

   assign o_ledr = ledr;
   assign o_hex  = hex;

   // Status/control block per event source: key, switch, timer
   generate
      for (genvar i = 0; i < NUM_CTRL; i++) begin : g_ctrl
         io_status_ctrl u_ctrl (
            .clk         (i_clk),
            .reset_n     (i_reset_n),
            .evt         (evt_v[i]),
            .clr_by_read (clr_v[i]),
            .wr_en       (wr_v[i]),
            .wr_data     (wr_ctrl),
            .ready       (rdy_v[i]),
            .overrun     (ovr_v[i]),
            .ie          (ie_v[i])
         );
      end
   endgenerate

   // Registered interrupt: any enabled source with ready set
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |(rdy_v & ie_v);
      end
   end

   assign o_irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_io_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_io_responder                                                   |
// | Scoreboard bench: requests push expected responses, a monitor pops  |
// | and compares them whenever the slave answers.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_wb_io_responder;

   localparam int          PRESCALE = 4;
   localparam logic [15:0] PAGE     = 16'hFFFF;

   localparam logic [13:0] KDATA = 14'h000;
   localparam logic [13:0] SDATA = 14'h001;
   localparam logic [13:0] LEDR  = 14'h002;
   localparam logic [13:0] HEX   = 14'h003;
   localparam logic [13:0] TCNT  = 14'h008;
   localparam logic [13:0] TLIM  = 14'h009;
   localparam logic [13:0] KCTRL = 14'h040;
   localparam logic [13:0] SCTRL = 14'h041;
   localparam logic [13:0] TCTL  = 14'h048;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [29:0] wb_addr;
   logic [31:0] wb_mosi;
   logic [3:0]  wb_sel;
   logic        wb_ack;
   logic        wb_stall;
   logic        wb_err;
   logic [31:0] wb_miso;
   logic [3:0]  i_key;
   logic [9:0]  i_sw;
   logic [9:0]  o_ledr;
   logic [23:0] o_hex;
   logic        o_irq;

   wb_io_responder #(.IO_PAGE(PAGE), .PRESCALE(PRESCALE)) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .wb_cyc    (wb_cyc),
      .wb_stb    (wb_stb),
      .wb_we     (wb_we),
      .wb_addr   (wb_addr),
      .wb_mosi   (wb_mosi),
      .wb_sel    (wb_sel),
      .wb_ack    (wb_ack),
      .wb_stall  (wb_stall),
      .wb_err    (wb_err),
      .wb_miso   (wb_miso),
      .i_key     (i_key),
      .i_sw      (i_sw),
      .o_ledr    (o_ledr),
      .o_hex     (o_hex),
      .o_irq     (o_irq)
   );

   always #5 i_clk = ~i_clk;

   // Edge counter: after edge N (and before N+1) cyc == N
   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          due;
      bit          err;
      logic [31:0] data;
      string       nm;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;

   // Reference model of the register file
   bit   [9:0]  m_ledr;
   bit   [23:0] m_hex;
   bit   [31:0] m_tcnt;
   bit   [31:0] m_tlim;
   bit          m_rdy [3];
   bit          m_ovr [3];
   bit          m_ie  [3];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // Monitor: compare every response against the oldest outstanding expectation
   always @(negedge i_clk) begin
      if (wb_ack || wb_err) begin
         if (sbq.size() == 0) begin
            chk("unexpected response", {30'd0, wb_err, wb_ack}, 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            chk({mon_e.nm, " resp"}, {30'd0, wb_err, wb_ack}, mon_e.err ? 32'd2 : 32'd1);
            chk({mon_e.nm, " data"}, wb_miso, mon_e.data);
            chk({mon_e.nm, " cycle"}, cyc, mon_e.due);
            chk({mon_e.nm, " stall"}, {31'd0, wb_stall}, 32'd0);
         end
      end else if (sbq.size() != 0 && sbq[0].due <= cyc) begin
         mon_e = sbq.pop_front();
         chk({mon_e.nm, " missing"}, {30'd0, wb_err, wb_ack}, mon_e.err ? 32'd2 : 32'd1);
      end
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle(input int n);
      wb_stb = 1'b0;
      repeat (n) step();
   endtask

   // Wait so that the next request is accepted at edge e
   task automatic issue_at(input int e);
      while (cyc + 1 < e) idle(1);
   endtask

   task automatic req(input bit we, input logic [15:0] page, input logic [13:0] off,
                      input logic [31:0] d, input logic [3:0] sel, input bit resp,
                      input bit err, input logic [31:0] exp, input string nm);
      wb_cyc  = 1'b1;
      wb_stb  = 1'b1;
      wb_we   = we;
      wb_addr = {page, off};
      wb_mosi = d;
      wb_sel  = sel;
      if (resp) sbq.push_back('{due: cyc + 1, err: err, data: err ? 32'd0 : exp, nm: nm});
      step();
      wb_stb = 1'b0;
   endtask

   function automatic bit is_mapped(input logic [13:0] off);
      return off inside {KDATA, SDATA, LEDR, HEX, TCNT, TLIM, KCTRL, SCTRL, TCTL};
   endfunction

   function automatic logic [31:0] ctrl_val(input int i);
      return {27'd0, m_ie[i], 2'b00, m_ovr[i], m_rdy[i]};
   endfunction

   function automatic int ctrl_idx(input logic [13:0] off);
      return (off == KCTRL) ? 0 : (off == SCTRL) ? 1 : 2;
   endfunction

   // Spec rule for a source event
   task automatic model_event(input int i);
      if (m_rdy[i]) m_ovr[i] = 1'b1;
      m_rdy[i] = 1'b1;
   endtask

   task automatic model_reset();
      m_ledr = '0; m_hex = '0; m_tcnt = '0; m_tlim = '0;
      for (int i = 0; i < 3; i++) begin
         m_rdy[i] = 1'b0; m_ovr[i] = 1'b0; m_ie[i] = 1'b0;
      end
   endtask

   // Model-predicted access to the IO page
   task automatic macc(input bit we, input logic [13:0] off, input logic [31:0] d,
                       input logic [3:0] sel);
      bit          err;
      logic [31:0] rd;
      err = !is_mapped(off) || (we && (sel != 4'hF || off == KDATA || off == SDATA));
      rd  = '0;
      if (!err) begin
         if (we) begin
            case (off)
               LEDR:  m_ledr = d[9:0];
               HEX:   m_hex  = d[23:0];
               TCNT:  m_tcnt = d;
               TLIM:  m_tlim = d;
               default: begin
                  if (!d[0]) m_rdy[ctrl_idx(off)] = 1'b0;
                  if (!d[1]) m_ovr[ctrl_idx(off)] = 1'b0;
                  m_ie[ctrl_idx(off)] = d[4];
               end
            endcase
         end else begin
            case (off)
               KDATA: begin rd = {28'd0, i_key}; m_rdy[0] = 1'b0; end
               SDATA: begin rd = {22'd0, i_sw};  m_rdy[1] = 1'b0; end
               LEDR:  rd = {22'd0, m_ledr};
               HEX:   rd = {8'd0, m_hex};
               TCNT:  rd = m_tcnt;
               TLIM:  rd = m_tlim;
               default: rd = ctrl_val(ctrl_idx(off));
            endcase
         end
      end
      req(we, PAGE, off, d, sel, 1'b1, err, rd,
          $sformatf("%s %03h", we ? "wr" : "rd", off));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d outstanding", sbq.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int          a;
      int          b;
      int          r;
      logic [13:0] off;
      logic [15:0] page;
      logic [3:0]  sel;
      logic [13:0] rd_list [8];

      rd_list = '{KDATA, SDATA, LEDR, HEX, TLIM, KCTRL, SCTRL, TCTL};
      i_reset_n = 1'b0;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      wb_addr = '0; wb_mosi = '0; wb_sel = '0;
      i_key = 4'b0000;
      i_sw  = 10'($urandom) | 10'h200;
      model_reset();

      // ---- reset and start-up: no spurious switch event ----
      repeat (3) step();
      chk("reset ledr", {22'd0, o_ledr}, 32'd0);
      chk("reset hex", {8'd0, o_hex}, 32'd0);
      chk("reset irq", {31'd0, o_irq}, 32'd0);
      i_reset_n = 1'b1;
      macc(1'b0, LEDR, '0, 4'hF);
      macc(1'b0, HEX, '0, 4'hF);
      req(1'b0, PAGE, TCNT, '0, 4'hF, 1'b1, 1'b0, 32'd0, "rd tcnt after reset");
      macc(1'b0, KCTRL, '0, 4'hF);
      idle(4);
      macc(1'b0, SCTRL, '0, 4'hF);
      macc(1'b0, SDATA, '0, 4'hF);
      chk("irq after reset", {31'd0, o_irq}, 32'd0);

      // ---- LEDR write/readback and partial-select error ----
      macc(1'b1, LEDR, 32'h3FF, 4'hF);
      chk("o_ledr after write", {22'd0, o_ledr}, 32'h3FF);
      macc(1'b0, LEDR, '0, 4'hF);
      macc(1'b1, LEDR, 32'h0AA, 4'b0011);
      macc(1'b0, LEDR, '0, 4'hF);
      chk("o_ledr after sel err", {22'd0, o_ledr}, {22'd0, m_ledr});

      // ---- key events, overrun, clear by read and by write-0 ----
      i_key = 4'b0010; model_event(0);
      idle(5);
      macc(1'b0, KCTRL, '0, 4'hF);
      i_key = 4'b0110; model_event(0);
      idle(5);
      macc(1'b0, KCTRL, '0, 4'hF);
      macc(1'b0, KDATA, '0, 4'hF);
      macc(1'b0, KCTRL, '0, 4'hF);
      macc(1'b1, KCTRL, 32'h0, 4'hF);
      macc(1'b0, KCTRL, '0, 4'hF);

      // ---- switch event, write to read-only data, unmapped, off-page ----
      i_sw = i_sw ^ 10'h011; model_event(1);
      idle(5);
      macc(1'b0, SCTRL, '0, 4'hF);
      macc(1'b1, SDATA, 32'hFFFF_FFFF, 4'hF);
      macc(1'b0, SDATA, '0, 4'hF);
      macc(1'b0, SCTRL, '0, 4'hF);
      macc(1'b0, 14'h3FF, '0, 4'hF);
      req(1'b0, 16'h0000, LEDR, '0, 4'hF, 1'b0, 1'b0, '0, "off-page rd");
      req(1'b1, 16'hFFFE, LEDR, 32'h155, 4'hF, 1'b0, 1'b0, '0, "off-page wr");
      macc(1'b0, LEDR, '0, 4'hF);

      // ---- randomized traffic, inputs static, timer limit 0 ----
      for (int n = 0; n < 300; n++) begin
         r   = $urandom_range(0, 9);
         sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
         case (r)
            0: idle($urandom_range(1, 2));
            2: macc(1'b1, LEDR, $urandom, sel);
            3: macc(1'b1, HEX, $urandom, sel);
            4: begin
               off = ($urandom_range(0, 2) == 0) ? KCTRL :
                     ($urandom_range(0, 1) == 0) ? SCTRL : TCTL;
               macc(1'b1, off, $urandom, sel);
            end
            5: begin
               off = 14'($urandom);
               if (is_mapped(off)) off = 14'h3FF;
               macc(1'($urandom), off, $urandom, sel);
            end
            6: macc(1'b1, ($urandom_range(0, 1) == 0) ? KDATA : SDATA, $urandom, 4'hF);
            7: begin
               page = 16'($urandom);
               if (page == PAGE) page = 16'h1234;
               req(1'($urandom), page, rd_list[$urandom_range(0, 7)], $urandom, sel,
                   1'b0, 1'b0, '0, "off-page");
            end
            default: macc(1'b0, rd_list[$urandom_range(0, 7)], '0, 4'hF);
         endcase
      end
      idle(3);
      chk("o_ledr random", {22'd0, o_ledr}, {22'd0, m_ledr});
      chk("o_hex random", {8'd0, o_hex}, {8'd0, m_hex});
      chk("irq random", {31'd0, o_irq},
          {31'd0, (m_rdy[0] & m_ie[0]) | (m_rdy[1] & m_ie[1]) | (m_rdy[2] & m_ie[2])});

      // ---- timer: free-running wrap with limit 0, no event ----
      macc(1'b1, KCTRL, 32'h0, 4'hF);
      macc(1'b1, SCTRL, 32'h0, 4'hF);
      b = cyc + 1;
      macc(1'b1, TLIM, 32'h0, 4'hF);
      req(1'b1, PAGE, TCNT, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, '0, "wr tcnt max");
      issue_at(b + 5);
      req(1'b0, PAGE, TCNT, '0, 4'hF, 1'b1, 1'b0, 32'd0, "rd tcnt wrap");
      macc(1'b0, TCTL, '0, 4'hF);

      // ---- timer: limit 3, ticks every PRESCALE cycles, ready then overrun ----
      idle(1);
      a = cyc + 1;
      macc(1'b1, TLIM, 32'd3, 4'hF);
      req(1'b1, PAGE, TCNT, 32'd0, 4'hF, 1'b1, 1'b0, '0, "wr tcnt 0");
      macc(1'b1, TCTL, 32'h10, 4'hF);
      for (int e = a + 3; e <= a + 30; e++) begin
         if (((e - a) % 2) == 0)
            req(1'b0, PAGE, TCNT, '0, 4'hF, 1'b1, 1'b0,
                32'(((e - 1 - a) / PRESCALE) % 3), $sformatf("rd tcnt @%0d", e - a));
         else
            req(1'b0, PAGE, TCTL, '0, 4'hF, 1'b1, 1'b0,
                32'h10 | ((e - 1 >= a + 12) ? 32'd1 : 32'd0) | ((e - 1 >= a + 24) ? 32'd2 : 32'd0),
                $sformatf("rd tctl @%0d", e - a));
         chk($sformatf("irq @%0d", e - a), {31'd0, o_irq}, (e >= a + 13) ? 32'd1 : 32'd0);
      end
      model_event(2); model_event(2);

      // ---- dropped cyc suppresses the response ----
      req(1'b0, PAGE, LEDR, '0, 4'hF, 1'b0, 1'b0, '0, "suppressed rd");
      wb_cyc = 1'b0;
      idle(1);
      wb_cyc = 1'b1;
      macc(1'b0, HEX, '0, 4'hF);

      // ---- reset with a request at the reset edge ----
      macc(1'b0, LEDR, '0, 4'hF);
      i_reset_n = 1'b0;
      req(1'b0, PAGE, HEX, '0, 4'hF, 1'b0, 1'b0, '0, "rd during reset");
      chk("ack in reset", {31'd0, wb_ack}, 32'd0);
      chk("err in reset", {31'd0, wb_err}, 32'd0);
      chk("ledr in reset", {22'd0, o_ledr}, 32'd0);
      chk("hex in reset", {8'd0, o_hex}, 32'd0);
      idle(1);
      chk("irq in reset", {31'd0, o_irq}, 32'd0);
      model_reset();
      i_reset_n = 1'b1;
      req(1'b0, PAGE, TCNT, '0, 4'hF, 1'b1, 1'b0, 32'd0, "rd tcnt after reset 2");
      macc(1'b0, TLIM, '0, 4'hF);
      macc(1'b0, TCTL, '0, 4'hF);
      macc(1'b0, LEDR, '0, 4'hF);
      macc(1'b0, HEX, '0, 4'hF);
      macc(1'b0, KCTRL, '0, 4'hF);
      macc(1'b0, SCTRL, '0, 4'hF);
      macc(1'b0, KDATA, '0, 4'hF);

      idle(4);
      chk("scoreboard drained", sbq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
